// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and LSU
// writeback paths, with a pending-write scoreboard for RAW hazard detection.
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd
);

  typedef enum logic {PRI_REQ0, PRI_REQ1} pri_t;

  pri_t            pri, pri_next;
  logic            grant0, grant1, xfer;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;
  logic [NREG-1:0] busy_q, busy_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pri <= PRI_REQ0;
    else     pri <= pri_next;
  end

  // The pointer only contests a tie; a lone requester is granted immediately.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    pri_next = pri;
    if (req0_valid && req1_valid) begin
      if (pri == PRI_REQ0) grant0 = 1'b1;
      else                 grant1 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
    if (grant0)      pri_next = PRI_REQ1;
    else if (grant1) pri_next = PRI_REQ0;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign win_rd     = grant1 ? req1_rd   : req0_rd;
  assign win_data   = grant1 ? req1_data : req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= xfer && (win_rd != '0);
      if (xfer) begin
        rf_rd <= win_rd;
        rf_wd <= win_data;
      end
    end
  end

  // Set is applied after clear so a fresh issue outranks a retiring write.
  always_comb begin
    busy_next = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (rf_we && (rf_rd == AW'(r)))       busy_next[r] = 1'b0;
      if (iss_valid && (iss_rd == AW'(r)))  busy_next[r] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_next;
  end

  assign busy   = busy_q;
  assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2];

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (write enable, destination index, write data) between two writeback requesters: req0 is the ALU pipe and req1 is the load/store unit.
- Round-robin arbitration with valid/ready handshakes.
- Holds a 32-entry pending-write scoreboard that the issue stage uses to stall on RAW hazards.
- Sits between the execute/memory stages and the register file; its registered outputs drive the register file write port directly.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register index width (log2 NREG).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  ALU writeback request.
- req0_rd  input  AW  ALU destination register.
- req0_data  input  XLEN  ALU result.
- req0_ready  output  1  ALU request accepted this cycle (combinational).
- req1_valid  input  1  LSU writeback request.
- req1_rd  input  AW  LSU destination register.
- req1_data  input  XLEN  LSU load data.
- req1_ready  output  1  LSU request accepted this cycle (combinational).
- iss_valid  input  1  instruction issued that will write iss_rd.
- iss_rd  input  AW  destination of issued instruction.
- chk_rs1  input  AW  source 1 of the instruction in decode.
- chk_rs2  input  AW  source 2 of the instruction in decode.
- hazard  output  1  busy[chk_rs1] | busy[chk_rs2] (combinational).
- busy  output  NREG  pending-write bit per register.
- rf_we  output  1  register file write enable (registered).
- rf_rd  output  AW  register file write index (registered).
- rf_wd  output  XLEN  register file write data (registered).

Behaviour:
- Reset (async assert, sync-safe release):
  - rf_we=0, rf_rd=0, rf_wd=0, busy=0.
  - Priority pointer set to req0.
  - Any transfer in flight is dropped; no register file write occurs.
- Handshake:
  - A transfer occurs when reqN_valid & reqN_ready.
  - A requester holds valid, rd and data stable until ready is seen.
  - Dropping valid before ready is a protocol violation; the resulting behaviour is unspecified.
- Arbitration: at most one ready is high per cycle.
  - Only one requester valid: it gets ready in the same cycle.
  - Both valid: the requester named by the priority pointer wins.
  - After any transfer, the pointer moves to the other requester.
  - No transfer: the pointer holds.
  - Consequence: with both requesters continuously valid, grants alternate 0,1,0,1.
- Write port, latency 1 cycle from transfer to register file write:
  - On the next edge after a transfer: rf_rd and rf_wd take the winner's rd and data; rf_we = (winner rd != 0).
  - No transfer: rf_we <= 0; rf_rd and rf_wd hold their previous values.
  - A write to x0 is accepted (ready high, transfer counted, pointer moves) but rf_we stays 0.
- Scoreboard: busy[r] is a flop per register.
  - Set on the edge where iss_valid & iss_rd==r & r!=0.
  - Cleared on the edge where rf_we & rf_rd==r. This is the same edge on which the register file captures the data, so a combinational read after that edge sees the new value.
  - Set and clear of the same r on the same edge: set wins (a new pending write).
  - busy[0] is constant 0; hazard on x0 is never asserted.
  - Issue logic never issues a second write to a register whose busy bit is set, except in the same cycle that register's write clears.
- hazard is purely combinational from busy and chk_rs1/chk_rs2; it carries no registered delay.
- Busy is not cleared by the handshake transfer itself, only by the registered rf_we one cycle later.

Test Plan:
- Reset mid-operation: transfer req0 rd=3 data=0xAA, then assert rst before the next edge -> rf_we stays 0, busy=0, register x3 unchanged; after release, pointer=req0.
- Single requester: req1_valid with rd=5 data=0x1234 -> req1_ready=1 in the same cycle; next cycle rf_we=1, rf_rd=5, rf_wd=0x1234; the following cycle rf_we=0.
- Contention: both valid continuously for 4 cycles (req0 rd=1..4, req1 rd=5..8) -> grant order req0,req1,req0,req1; rf_rd sequence 1,5,2,6, each one cycle after its grant.
- Scoreboard: iss_valid rd=7 -> busy[7]=1 next cycle; hazard=1 with chk_rs1=7; req0 writes rd=7 -> busy[7] clears on the same edge that rf_we=1 is captured; hazard=0 afterward.
- Set/clear collision: rf_we pending for rd=9 while iss_valid rd=9 in the same cycle -> busy[9] remains 1.
- x0 handling: iss_valid rd=0 -> busy[0] stays 0; req0 rd=0 data=0xFFFF -> ready=1, pointer moves, rf_we=0.
